// File: rtl/cube0414_pkg.sv
// Shared constants and encodings for the CUBE0414 host-side byte protocol.
package cube0414_pkg;

    localparam logic [7:0] CMD_ADDR_WR = 8'hcc;
    localparam logic [7:0] CMD_DATA_WR = 8'hda;

    localparam int LAYERS      = 8;
    localparam int PIXELS      = 64;
    localparam int COLORS      = 3;
    localparam int FRAME_BYTES = LAYERS * PIXELS * COLORS;
    localparam int IDX_W       = 11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_FETCH = 3'd2,
        ST_DATA  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic {
        MODE_FRAME = 1'b0,
        MODE_ADDR  = 1'b1
    } mode_t;

    function automatic logic [IDX_W-1:0] last_index(input mode_t m);
        return (m == MODE_ADDR) ? IDX_W'(PIXELS - 1) : IDX_W'(FRAME_BYTES - 1);
    endfunction

endpackage

// File: rtl/cube_frame_tx.sv
// CUBE0414 transmitter: command byte, then address table or full frame read from
// a source RAM, streamed to an SPI master over a valid/ready byte handshake.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for a start pulse
// ST_CMD   | command byte (dc=0) offered until accepted
// ST_FETCH | rd_addr_out presented; source byte captured at end of cycle
// ST_DATA  | data byte (dc=1) offered until accepted
// ST_DONE  | done_out pulse, busy_out drops on exit
module cube_frame_tx
    import cube0414_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_addr_in,
    input  logic             start_frame_in,
    output logic             rd_sel_out,
    output logic [IDX_W-1:0] rd_addr_out,
    input  logic [7:0]       rd_data_in,
    output logic             byte_valid_out,
    input  logic             byte_ready_in,
    output logic [7:0]       byte_data_out,
    output logic             dc_out,
    output logic             busy_out,
    output logic             done_out
);

    state_t           r_state;
    mode_t            r_mode;
    logic [IDX_W-1:0] r_idx;
    logic             r_rd_sel;
    logic             r_valid;
    logic [7:0]       r_data;
    logic             r_dc;
    logic             r_busy;
    logic             r_done;

    logic [IDX_W-1:0] w_last;
    logic [IDX_W-1:0] w_idx_next;

    assign w_last     = last_index(r_mode);
    assign w_idx_next = r_idx + IDX_W'(1);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state  <= ST_IDLE;
            r_mode   <= MODE_FRAME;
            r_idx    <= '0;
            r_rd_sel <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_dc     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Address start takes priority when both arrive together.
                    if (start_addr_in || start_frame_in) begin
                        r_mode   <= start_addr_in ? MODE_ADDR : MODE_FRAME;
                        r_rd_sel <= start_addr_in;
                        r_data   <= start_addr_in ? CMD_ADDR_WR : CMD_DATA_WR;
                        r_dc     <= 1'b0;
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (byte_ready_in) begin
                        r_valid <= 1'b0;
                        r_idx   <= '0;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_data  <= rd_data_in;
                    r_dc    <= 1'b1;
                    r_valid <= 1'b1;
                    r_state <= ST_DATA;
                end
                ST_DATA: begin
                    if (byte_ready_in) begin
                        r_valid <= 1'b0;
                        if (r_idx == w_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= w_idx_next;
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rd_sel_out     = r_rd_sel;
    assign rd_addr_out    = r_idx;
    assign byte_valid_out = r_valid;
    assign byte_data_out  = r_data;
    assign dc_out         = r_dc;
    assign busy_out       = r_busy;
    assign done_out       = r_done;

endmodule

// File: tb/tb_cube_frame_tx.sv
// Bench for cube_frame_tx: byte-stream scoreboard, stall stability checks and a
// loopback receiver model rebuilding the address table and the 8x64x3 frame.
module tb_cube_frame_tx;
    import cube0414_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_addr = 1'b0;
    logic        start_frame = 1'b0;
    logic        ready = 1'b1;
    logic        rd_sel;
    logic [10:0] rd_addr;
    logic [7:0]  rd_data;
    logic        valid, dc, busy, done;
    logic [7:0]  bdata;

    always #5 clk = ~clk;

    cube_frame_tx dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .start_addr_in (start_addr),
        .start_frame_in(start_frame),
        .rd_sel_out    (rd_sel),
        .rd_addr_out   (rd_addr),
        .rd_data_in    (rd_data),
        .byte_valid_out(valid),
        .byte_ready_in (ready),
        .byte_data_out (bdata),
        .dc_out        (dc),
        .busy_out      (busy),
        .done_out      (done)
    );

    // Source memories; read data is settled by the end of the FETCH cycle.
    logic [7:0] cmem [FRAME_BYTES];
    logic [7:0] amem [PIXELS];
    assign rd_data = rd_sel ? amem[rd_addr[5:0]]
                   : ((rd_addr < 11'(FRAME_BYTES)) ? cmem[rd_addr] : 8'h00);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    logic [8:0] exp_q[$];
    logic [7:0] cap[$];
    bit         exp_sel = 1'b0;
    bit         bp_en = 1'b0;
    int         cyc = 0, last_start = 0, last_done = 0, done_cnt = 0, acc_data = 0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_byte = '0;

    int         rx_mode = 0, rx_cnt = 0, frame_rdy_cnt = 0;
    logic [7:0] rx_tab [PIXELS];
    logic [7:0] rx_frm [LAYERS][PIXELS][COLORS];

    task automatic rx_byte(input logic d, input logic [7:0] b);
        if (!d) begin
            rx_cnt  = 0;
            rx_mode = (b == CMD_ADDR_WR) ? 1 : ((b == CMD_DATA_WR) ? 2 : 0);
        end else if (rx_mode == 1) begin
            rx_tab[rx_cnt] = b;
            rx_cnt++;
            if (rx_cnt == PIXELS) rx_mode = 0;
        end else if (rx_mode == 2) begin
            rx_frm[rx_cnt / (PIXELS * COLORS)][(rx_cnt / COLORS) % PIXELS][rx_cnt % COLORS] = b;
            rx_cnt++;
            if (rx_cnt == FRAME_BYTES) begin
                rx_mode = 0;
                frame_rdy_cnt++;
            end
        end
    endtask

    // Expected stream: command byte, then the source contents in protocol order.
    task automatic push_stream(input bit is_addr);
        exp_sel = is_addr;
        cap.delete();
        if (is_addr) begin
            exp_q.push_back({1'b0, CMD_ADDR_WR});
            for (int p = 0; p < PIXELS; p++) exp_q.push_back({1'b1, amem[p]});
        end else begin
            exp_q.push_back({1'b0, CMD_DATA_WR});
            for (int l = 0; l < LAYERS; l++)
                for (int p = 0; p < PIXELS; p++)
                    for (int c = 0; c < COLORS; c++)
                        exp_q.push_back({1'b1, cmem[(l * PIXELS + p) * COLORS + c]});
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (start_addr || start_frame) last_start = cyc;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(valid), 32'd1);
                chk("stall_byte", 32'({dc, bdata}), 32'(prev_byte));
            end
            if (busy) chk("rd_sel", 32'(rd_sel), 32'(exp_sel));
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_byte: got dc=%0d data=0x%0h, expected no byte", dc, bdata);
                end else begin
                    chk("byte", 32'({dc, bdata}), 32'(exp_q.pop_front()));
                end
                rx_byte(dc, bdata);
                if (dc) begin
                    acc_data++;
                    cap.push_back(bdata);
                end
            end
            if (done) begin
                done_cnt++;
                last_done = cyc;
                chk("done_q_empty", 32'(exp_q.size()), 32'd0);
            end
            prev_stall = valid && !ready;
            prev_byte  = {dc, bdata};
        end
    end

    always begin
        @(posedge clk);
        #1;
        ready = bp_en ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    task automatic pulse(input bit a, input bit f);
        @(posedge clk); #1;
        start_addr  = a;
        start_frame = f;
        @(posedge clk); #1;
        start_addr  = 1'b0;
        start_frame = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit poke);
        bit got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done) begin
                got = 1'b1;
                if (poke) begin
                    start_frame = 1'b1;
                    @(posedge clk); #1;
                    start_frame = 1'b0;
                end
                break;
            end
        end
        chk("done_seen", 32'(got), 32'd1);
        @(negedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int fr0, bad;
        for (int i = 0; i < FRAME_BYTES; i++) cmem[i] = 8'(i);
        for (int i = 0; i < PIXELS; i++) amem[i] = 8'(63 - i);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dc", 32'(dc), 32'd0);
        chk("rst_data", 32'(bdata), 32'd0);
        chk("rst_addr", 32'(rd_addr), 32'd0);
        chk("rst_sel", 32'(rd_sel), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Frame, ready tied high
        push_stream(1'b0);
        pulse(1'b0, 1'b1);
        wait_done(5000, 1'b0);
        chk("frame_latency", 32'(last_done - last_start), 32'd3074);
        chk("frame_len", 32'(cap.size()), 32'd1536);
        chk("frame_b0", 32'(cap[0]), 32'h00);
        chk("frame_b300", 32'(cap[300]), 32'h2c);
        chk("frame_b1535", 32'(cap[1535]), 32'hff);

        // Address table
        push_stream(1'b1);
        pulse(1'b1, 1'b0);
        wait_done(500, 1'b0);
        chk("addr_len", 32'(cap.size()), 32'd64);
        chk("addr_b0", 32'(cap[0]), 32'h3f);
        chk("addr_b63", 32'(cap[63]), 32'h00);

        // Frame under random backpressure
        bp_en = 1'b1;
        push_stream(1'b0);
        pulse(1'b0, 1'b1);
        wait_done(20000, 1'b0);
        bp_en = 1'b0;
        chk("bp_len", 32'(cap.size()), 32'd1536);
        chk("bp_b700", 32'(cap[700]), 32'hbc);

        // Simultaneous starts, start while busy, start during DONE
        push_stream(1'b1);
        pulse(1'b1, 1'b1);
        repeat (20) @(posedge clk);
        pulse(1'b0, 1'b1);
        wait_done(500, 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("ignored_busy", 32'(busy), 32'd0);
        chk("ignored_q", 32'(exp_q.size()), 32'd0);

        // Reset abort at data byte 700, then full retransmit
        push_stream(1'b0);
        acc_data = 0;
        pulse(1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (acc_data >= 700) break;
        end
        chk("abort_reached", 32'(acc_data >= 700), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("abort_outputs", 32'({valid, dc, busy, done, rd_sel, bdata, rd_addr}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        push_stream(1'b0);
        pulse(1'b0, 1'b1);
        wait_done(5000, 1'b0);
        chk("restart_len", 32'(cap.size()), 32'd1536);
        chk("restart_b0", 32'(cap[0]), 32'h00);

        // Loopback: table then frame with a distinct pattern
        for (int i = 0; i < FRAME_BYTES; i++) cmem[i] = 8'(i * 7 + 3);
        fr0 = frame_rdy_cnt;
        push_stream(1'b1);
        pulse(1'b1, 1'b0);
        wait_done(500, 1'b0);
        push_stream(1'b0);
        pulse(1'b0, 1'b1);
        wait_done(5000, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("frame_rdy_once", 32'(frame_rdy_cnt - fr0), 32'd1);
        bad = 0;
        for (int p = 0; p < PIXELS; p++) if (rx_tab[p] !== amem[p]) bad++;
        chk("rx_table_bad", 32'(bad), 32'd0);
        bad = 0;
        for (int l = 0; l < LAYERS; l++)
            for (int p = 0; p < PIXELS; p++)
                for (int c = 0; c < COLORS; c++)
                    if (rx_frm[l][p][c] !== cmem[(l * PIXELS + p) * COLORS + c]) bad++;
        chk("rx_frame_bad", 32'(bad), 32'd0);
        chk("rx_l0p1c0", 32'(rx_frm[0][1][0]), 32'h18);
        chk("rx_l7p63c2", 32'(rx_frm[7][63][2]), 32'hfc);
        chk("done_total", 32'(done_cnt), 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
